// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
//   Shared definitions for the UART transmit arbiter slice: the arbiter FSM
//   state type, default parameter values and a small index-wrap helper used by
//   the round-robin search.
//   No ports (package).
package uart_arb_pkg;

  localparam int DEFAULT_NUM_REQ        = 4;
  localparam int DEFAULT_START_HOLD     = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 200000;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    COMPLETE,
    GAP
  } arb_state_e;

  // Wraps an index that may exceed n-1 by less than n back into 0..n-1.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if
//   Bundles the requester-side handshake and the UART-transmitter-side strobes
//   of the arbiter.
//   Requester side : req, req_data (byte i on [8i+7:8i]), grant, done,
//                    done_err, busy, timeout
//   UART side      : tx_start, tx_data, tx_done, tx_err
//   Modports       : master - environment (requesters + UART transmitter)
//                    slave  - the arbiter itself
interface uart_tx_arb_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
);

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic                 done_err;
  logic                 busy;
  logic                 timeout;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 tx_err;

  modport master (
    output req, req_data, tx_done, tx_err,
    input  grant, done, done_err, busy, timeout, tx_start, tx_data
  );

  modport slave (
    input  req, req_data, tx_done, tx_err,
    output grant, done, done_err, busy, timeout, tx_start, tx_data
  );

endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick
//   Combinational round-robin search. Starting one past last_winner and
//   wrapping, returns the first requester with its req bit set.
//   Ports:
//     req         in   NUM_REQ   pending requests
//     last_winner in   IDX_W     index granted most recently
//     valid       out  1         at least one request pending
//     winner      out  IDX_W     selected index (last_winner when !valid)
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest pending requester
  // after last_winner is the one left in winner. Offset NUM_REQ lands on
  // last_winner itself, so it only wins when nobody else is pending.
  always_comb begin
    valid  = 1'b0;
    winner = last_winner;
    cand   = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'(wrap_idx(int'(last_winner) + off, NUM_REQ));
      if (req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Shares one UART transmitter between NUM_REQ requesters. In IDLE a
//   round-robin winner is granted and its byte captured; the transmitter is
//   strobed with tx_start for START_HOLD cycles, then the arbiter waits for a
//   rising edge on tx_done, reports completion with a one-cycle done pulse
//   (done_err flags a tx_err seen during the transfer) and waits in GAP for
//   tx_done to fall before arbitrating again.
//   Ports:
//     clk  in  system clock (posedge)
//     rst  in  asynchronous, active-high reset
//     bus  slave modport of uart_tx_arb_if (see interface for signal list)
//   Optional feature (macro UART_TX_ARB_TIMEOUT_EN): WAIT gives up after
//   TIMEOUT_CYCLES cycles without a tx_done rise, completing with done_err=1
//   and a timeout pulse. Without the macro WAIT has no time limit and timeout
//   is tied low.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int START_HOLD     = DEFAULT_START_HOLD,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic          clk,
  input logic          rst,
  uart_tx_arb_if.slave bus
);

  localparam int          IDX_W     = $clog2(NUM_REQ);
  localparam logic [15:0] HOLD_LAST = 16'(START_HOLD - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || START_HOLD < 1 || START_HOLD > 65536 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_tx_arb: parameter out of supported range");
  end

  arb_state_e         state_q, state_d;
  logic [15:0]        hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]   last_winner_q, last_winner_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               err_q, err_d;
  logic               tx_done_prev_q;
  logic               tx_done_rise;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [7:0]         pick_byte;
  logic [NUM_REQ-1:0] winner_onehot;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int          TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_flag_q, to_flag_d;
`endif

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req         (bus.req),
    .last_winner (last_winner_q),
    .valid       (pick_valid),
    .winner      (pick_idx)
  );

  // Constant-index mux keeps the byte select free of variable part-selects.
  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_byte = bus.req_data[8*i +: 8];
    end
  end

  assign tx_done_rise = bus.tx_done & ~tx_done_prev_q;

  // Next-state logic. The err flag is cleared when a new transfer is granted
  // and set by tx_err on any START/WAIT cycle, including the cycle in which
  // the tx_done rise is seen.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    last_winner_d = last_winner_q;
    tx_data_d     = tx_data_q;
    err_d         = err_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    to_flag_d     = to_flag_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d       = START;
          last_winner_d = pick_idx;
          tx_data_d     = pick_byte;
          hold_cnt_d    = '0;
          err_d         = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
          to_cnt_d      = '0;
          to_flag_d     = 1'b0;
`endif
        end
      end
      START: begin
        if (bus.tx_err) err_d = 1'b1;
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          state_d    = WAIT;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      WAIT: begin
        if (bus.tx_err) err_d = 1'b1;
        if (tx_done_rise) begin
          state_d = COMPLETE;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          state_d   = COMPLETE;
          err_d     = 1'b1;
          to_flag_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      COMPLETE: begin
        state_d = GAP;
      end
      GAP: begin
        // Hold off until the transmitter drops tx_done so the same level is
        // never taken as the completion of the next transfer.
        if (!bus.tx_done) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any transfer with no completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      hold_cnt_q     <= '0;
      last_winner_q  <= IDX_W'(NUM_REQ - 1);
      tx_data_q      <= 8'h00;
      err_q          <= 1'b0;
      tx_done_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      last_winner_q  <= last_winner_d;
      tx_data_q      <= tx_data_d;
      err_q          <= err_d;
      tx_done_prev_q <= bus.tx_done;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  // Timeout counter and the flag recording that WAIT ended by timing out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end
`endif

  always_comb begin
    winner_onehot                = '0;
    winner_onehot[last_winner_q] = 1'b1;
  end

  // Outputs decode from registered state so they drop with reset in the same
  // cycle. Grant is the first START cycle, i.e. the cycle after the winner
  // was selected in IDLE.
  assign bus.grant    = (state_q == START && hold_cnt_q == 16'd0) ? winner_onehot : '0;
  assign bus.done     = (state_q == COMPLETE) ? winner_onehot : '0;
  assign bus.done_err = (state_q == COMPLETE) & err_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.tx_start = (state_q == START);
  assign bus.tx_data  = tx_data_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign bus.timeout  = (state_q == COMPLETE) & to_flag_q;
`else
  assign bus.timeout  = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter START_HOLD, 16, clk cycles tx_start is held high; integrator sets it to at least one tx_clk period.
REQ-003 Parameter TIMEOUT_CYCLES, 200000, clk cycles allowed between end of START and tx_done rise (macro builds only).
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req  input  NUM_REQ  per-requester transfer request, level.
REQ-007 req_data  input  8*NUM_REQ  byte for requester i on bits [8i+7:8i].
REQ-008 grant  output  NUM_REQ  one-hot, one-cycle pulse: request accepted, data captured.
REQ-009 done  output  NUM_REQ  one-hot, one-cycle pulse to the granted requester at completion.
REQ-010 done_err  output  1  valid with done; 1 = tx_err seen or timeout.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 tx_start  output  1  start strobe to the UART transmitter.
REQ-013 tx_data  output  8  captured byte to the UART transmitter, stable from grant until return to IDLE.
REQ-014 tx_done  input  1  transmitter completion level (held one tx_clk period).
REQ-015 tx_err  input  1  transmitter error level.
REQ-016 timeout  output  1  one-cycle pulse coincident with done when a timeout ends a transfer.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT, COMPLETE, GAP.
REQ-018 IDLE: if any req bit set, pick winner round-robin, pulse grant[w], capture req_data[w] into tx_data, store w, go START next cycle; latency req->grant = 1 cycle.
REQ-019 Round-robin: search begins at (last_winner+1) mod NUM_REQ; last_winner resets to NUM_REQ-1, so req=all-ones after reset grants 0,1,2,3,0...
REQ-020 START: tx_start=1 for exactly START_HOLD cycles (16-bit counter), then WAIT.
REQ-021 WAIT: on tx_done rising edge (registered previous value, 0->1), go COMPLETE; tx_err sampled high at any cycle in START/WAIT sets a sticky err flag.
REQ-022 COMPLETE: one cycle; pulse done[w], done_err=err flag; go GAP.
REQ-023 GAP: remain until tx_done=0, then IDLE; prevents re-detecting the same tx_done level.
REQ-024 Arbitration occurs only in IDLE; req changes or drops during START..GAP SHALL NOT affect the current transfer.
REQ-025 A requester holding req high after its done SHALL compete again and lose to any other pending requester.
REQ-026 Single requester pending SHALL be granted regardless of pointer position.
REQ-027 grant, done, timeout SHALL never have more than one bit set, and never coincide with each other except done/timeout.

Reset
REQ-028 On rst: state IDLE, grant=0, done=0, done_err=0, busy=0, tx_start=0, tx_data=8'h00, timeout=0, counters 0, err flag 0, last_winner=NUM_REQ-1.
REQ-029 Reset mid-transfer SHALL abort immediately with no done pulse; first cycle after rst deassertion behaves as IDLE.

Configuration
REQ-030 Macro UART_TX_ARB_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT_CYCLES without tx_done rise, go COMPLETE with done_err=1 and timeout pulse, then GAP.
REQ-031 Macro undefined: WAIT waits indefinitely, no timeout counter synthesized, timeout port tied 0.

Structure
REQ-032 Package uart_arb_pkg SHALL hold the state enum, default NUM_REQ, START_HOLD and TIMEOUT_CYCLES constants.
REQ-033 Sub-module uart_rr_pick SHALL implement the combinational round-robin search (req, last_winner -> valid, winner index).

Verification
REQ-034 req=4'b0100, data2=8'hA5 -> grant=4'b0100 one cycle later, tx_data=8'hA5, tx_start high 16 cycles, tx_done pulse -> done=4'b0100, done_err=0.
REQ-035 req=4'b1111 held, model acks each transfer -> grant order 0,1,2,3,0, one done per grant.
REQ-036 tx_err=1 during WAIT of requester 1 -> done=4'b0010 with done_err=1; next transfer done_err=0.
REQ-037 req[3] dropped after grant -> transfer still completes, done=4'b1000.
REQ-038 rst asserted in WAIT -> outputs at reset values same cycle, no done; new req after release granted normally.
REQ-039 Macro defined, TIMEOUT_CYCLES=50, tx_done never rises -> timeout and done_err pulse 50 cycles after entering WAIT; macro undefined -> busy stays high.
